t08_cpu_sequencer: RTL and testbench

Multi-cycle sequencer for the team 08 RV32I core. It owns the instruction register and steps each instruction through fetch, decode, execute, optional memory access and writeback. It issues request/enable strobes to the memory handler, program counter and register file. The combinational control unit decodes the instruction-register output; the sequencer consumes its read/write/jump/register-write flags to pick the path.

---
 rtl/t08_cpu_sequencer.sv | 130 +++++++++++++
 tb/tb_t08_cpu_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t08_cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the team 08 RV32I core.
// Optional memory-wait timeout is compiled in with `define T08_SEQ_TIMEOUT_EN.
module t08_cpu_sequencer #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        run,
    input  logic        mem_done,
    input  logic [31:0] instr_in,
    input  logic        dec_read,
    input  logic        dec_write,
    input  logic        dec_jump,
    input  logic        dec_reg_write,
    input  logic        branch_taken,
    output logic [31:0] instr_out,
    output logic        fetch_req,
    output logic        mem_read_req,
    output logic        mem_write_req,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        reg_write_en,
    output logic [2:0]  state_out,
    output logic [31:0] instr_count,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        ERROR     = 3'd6
    } state_t;

    state_t state, state_next;
    logic   load_ir;

`ifdef T08_SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        wait_expired;

    // Cycles already spent waiting in the current FETCH/MEM visit.
    assign wait_expired = (wait_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_next    = state;
        load_ir       = 1'b0;
        fetch_req     = 1'b0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        pc_en         = 1'b0;
        reg_write_en  = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (mem_done) begin
                    load_ir    = 1'b1;
                    state_next = DECODE;
                end
`ifdef T08_SEQ_TIMEOUT_EN
                else if (wait_expired) state_next = ERROR;
`endif
            end
            DECODE:  state_next = EXECUTE;
            EXECUTE: state_next = (dec_read || dec_write) ? MEM : WRITEBACK;
            MEM: begin
                mem_read_req  = dec_read;
                mem_write_req = dec_write;
                if (mem_done) state_next = WRITEBACK;
`ifdef T08_SEQ_TIMEOUT_EN
                else if (wait_expired) state_next = ERROR;
`endif
            end
            WRITEBACK: begin
                pc_en        = 1'b1;
                reg_write_en = dec_reg_write;
                state_next   = run ? FETCH : IDLE;
            end
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state       <= IDLE;
            instr_out   <= RESET_INSTR;
            instr_count <= '0;
            pc_sel      <= 1'b0;
        end else begin
            state <= state_next;
            if (load_ir) instr_out <= instr_in;
            if (state == EXECUTE) pc_sel <= dec_jump | branch_taken;
            if (state == WRITEBACK) begin
                pc_sel      <= 1'b0;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

`ifdef T08_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!nRst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Counter restarts on every entry to a waiting state.
            if (((state_next == FETCH) || (state_next == MEM)) && (state_next == state))
                wait_cnt <= wait_cnt + 32'd1;
            else
                wait_cnt <= '0;
            if (state_next == ERROR) timeout_err <= 1'b1;
        end
    end
`else
    // Always 0; the parameter only matters when the timeout is compiled in.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign state_out = state;

endmodule

// File: tb/tb_t08_cpu_sequencer.sv
// Directed self-checking bench for t08_cpu_sequencer; dec_* flags are driven by hand
// as the control unit would decode each instruction.
module tb_t08_cpu_sequencer;

    logic        clk = 1'b0;
    logic        nRst;
    logic        run;
    logic        mem_done;
    logic [31:0] instr_in;
    logic        dec_read;
    logic        dec_write;
    logic        dec_jump;
    logic        dec_reg_write;
    logic        branch_taken;
    logic [31:0] instr_out;
    logic        fetch_req;
    logic        mem_read_req;
    logic        mem_write_req;
    logic        pc_en;
    logic        pc_sel;
    logic        reg_write_en;
    logic [2:0]  state_out;
    logic [31:0] instr_count;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_cyc   = 0;

    t08_cpu_sequencer #(
        .TIMEOUT_CYCLES(4),
        .RESET_INSTR   (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .run          (run),
        .mem_done     (mem_done),
        .instr_in     (instr_in),
        .dec_read     (dec_read),
        .dec_write    (dec_write),
        .dec_jump     (dec_jump),
        .dec_reg_write(dec_reg_write),
        .branch_taken (branch_taken),
        .instr_out    (instr_out),
        .fetch_req    (fetch_req),
        .mem_read_req (mem_read_req),
        .mem_write_req(mem_write_req),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .reg_write_en (reg_write_en),
        .state_out    (state_out),
        .instr_count  (instr_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sit on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] strobes();
        return {fetch_req, mem_read_req, mem_write_req, pc_en, reg_write_en};
    endfunction

    initial begin
        nRst = 1'b0; run = 1'b0; mem_done = 1'b0; instr_in = '0;
        dec_read = 1'b0; dec_write = 1'b0; dec_jump = 1'b0;
        dec_reg_write = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        step(); step();
        nRst = 1'b1;

        // Reset state held with run=0
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_state", 32'(state_out), 32'd0);
            check("rst_instr", instr_out, 32'h0000_0013);
            check("rst_count", instr_count, 32'd0);
            check("rst_strobes", 32'(strobes()), 32'd0);
            check("rst_pc_sel", 32'(pc_sel), 32'd0);
            check("rst_timeout", 32'(timeout_err), 32'd0);
        end

        // ADDI x1,x0,5 zero-wait, run stays high for back-to-back
        run = 1'b1; dec_reg_write = 1'b1;
        step();
        check("addi_fetch_state", 32'(state_out), 32'd1);
        check("addi_fetch_req", 32'(fetch_req), 32'd1);
        instr_in = 32'h0050_0093; mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("addi_decode_state", 32'(state_out), 32'd2);
        check("addi_ir", instr_out, 32'h0050_0093);
        check("addi_decode_fetch_req", 32'(fetch_req), 32'd0);
        step();
        check("addi_exec_state", 32'(state_out), 32'd3);
        step();
        check("addi_wb_state", 32'(state_out), 32'd5);
        check("addi_wb_pc_en", 32'(pc_en), 32'd1);
        check("addi_wb_reg_we", 32'(reg_write_en), 32'd1);
        check("addi_wb_pc_sel", 32'(pc_sel), 32'd0);
        check("addi_wb_count", instr_count, 32'd0);

        // LW: one FETCH wait, three MEM cycles -> 8 cycles FETCH entry through WRITEBACK
        dec_read = 1'b1; dec_reg_write = 1'b1;
        step();
        cyc = 1;
        check("b2b_fetch_state", 32'(state_out), 32'd1);
        check("addi_count", instr_count, 32'd1);
        check("lw_fetch_wait_req", 32'(fetch_req), 32'd1);
        step(); cyc++;
        check("lw_fetch_wait_state", 32'(state_out), 32'd1);
        instr_in = 32'h0000_A103; mem_done = 1'b1;
        step(); cyc++;
        mem_done = 1'b0;
        check("lw_ir", instr_out, 32'h0000_A103);
        step(); cyc++;
        check("lw_exec_state", 32'(state_out), 32'd3);
        rd_cyc = 0;
        step(); cyc++;
        check("lw_mem_state", 32'(state_out), 32'd4);
        check("lw_mem_write_req", 32'(mem_write_req), 32'd0);
        if (mem_read_req) rd_cyc++;
        step(); cyc++;
        if (mem_read_req) rd_cyc++;
        step(); cyc++;
        if (mem_read_req) rd_cyc++;
        mem_done = 1'b1; run = 1'b0;
        step(); cyc++;
        mem_done = 1'b0;
        if (mem_read_req) rd_cyc++;
        check("lw_read_req_cycles", 32'(rd_cyc), 32'd3);
        check("lw_wb_state", 32'(state_out), 32'd5);
        check("lw_total_cycles", 32'(cyc), 32'd8);
        check("lw_wb_reg_we", 32'(reg_write_en), 32'd1);
        check("lw_wb_pc_en", 32'(pc_en), 32'd1);
        dec_read = 1'b0; dec_reg_write = 1'b0;
        step();
        check("lw_idle_state", 32'(state_out), 32'd0);
        check("lw_count", instr_count, 32'd2);

        // mem_done in IDLE is ignored
        mem_done = 1'b1; instr_in = 32'hFFFF_FFFF;
        step();
        mem_done = 1'b0;
        check("idle_stray_state", 32'(state_out), 32'd0);
        check("idle_stray_ir", instr_out, 32'h0000_A103);

        // BEQ taken, with a stray mem_done during DECODE
        run = 1'b1;
        step();
        instr_in = 32'h0020_8463; mem_done = 1'b1;
        step();
        check("beq_ir", instr_out, 32'h0020_8463);
        instr_in = 32'hDEAD_BEEF;
        step();
        mem_done = 1'b0;
        check("beq_stray_state", 32'(state_out), 32'd3);
        check("beq_stray_ir", instr_out, 32'h0020_8463);
        branch_taken = 1'b1; run = 1'b0;
        step();
        branch_taken = 1'b0;
        check("beq_wb_pc_sel", 32'(pc_sel), 32'd1);
        check("beq_wb_pc_en", 32'(pc_en), 32'd1);
        check("beq_wb_reg_we", 32'(reg_write_en), 32'd0);
        step();
        check("beq_idle_state", 32'(state_out), 32'd0);
        check("beq_pc_sel_clear", 32'(pc_sel), 32'd0);
        check("beq_count", instr_count, 32'd3);

        // SW with run dropped during MEM
        run = 1'b1; dec_write = 1'b1;
        step();
        instr_in = 32'h0020_A023; mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        step();
        step();
        check("sw_mem_state", 32'(state_out), 32'd4);
        check("sw_mem_write_req", 32'(mem_write_req), 32'd1);
        check("sw_mem_read_req", 32'(mem_read_req), 32'd0);
        run = 1'b0;
        step();
        check("sw_mem_hold", 32'(state_out), 32'd4);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("sw_wb_state", 32'(state_out), 32'd5);
        check("sw_wb_reg_we", 32'(reg_write_en), 32'd0);
        check("sw_wb_pc_sel", 32'(pc_sel), 32'd0);
        dec_write = 1'b0;
        step();
        check("sw_idle_state", 32'(state_out), 32'd0);
        check("sw_count", instr_count, 32'd4);

        // Reset during FETCH drops the request and clears the counter
        run = 1'b1;
        step();
        check("rst2_fetch_state", 32'(state_out), 32'd1);
        nRst = 1'b0; run = 1'b0;
        step();
        nRst = 1'b1;
        check("rst2_state", 32'(state_out), 32'd0);
        check("rst2_count", instr_count, 32'd0);
        check("rst2_fetch_req", 32'(fetch_req), 32'd0);
        check("rst2_ir", instr_out, 32'h0000_0013);

        // FETCH with no mem_done
        run = 1'b1;
        step();
        run = 1'b0;
`ifdef T08_SEQ_TIMEOUT_EN
        for (int i = 0; i < 3; i++) step();
        check("to_still_fetch", 32'(state_out), 32'd1);
        step();
        check("to_error_state", 32'(state_out), 32'd6);
        check("to_err_flag", 32'(timeout_err), 32'd1);
        check("to_fetch_req", 32'(fetch_req), 32'd0);
        run = 1'b1; mem_done = 1'b1;
        step();
        check("to_error_hold", 32'(state_out), 32'd6);
`else
        for (int i = 0; i < 1000; i++) step();
        check("hang_fetch_req", 32'(fetch_req), 32'd1);
        check("hang_state", 32'(state_out), 32'd1);
        check("hang_timeout_err", 32'(timeout_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
